tron_arena_core: RTL and testbench

- Parametrised light-cycle arena engine with 2–4 players, a configurable grid, and a selectable wall mode (wrap-around or lethal).
- Holds one shared owner-tagged trail grid and runs round sequencing (clear, seed, play, game over).
- Keeps per-player win counts.
- Sits between the keyboard decoder (direction requests) and the VGA colour mapper (per-pixel owner lookup).

---
 rtl/tron_arena_core.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_tron_arena_core.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tron_arena_core.sv
// Light-cycle arena engine: shared owner-tagged trail grid, round FSM, per-player win counters.
// Latency: pixel lookup is 1 cycle; a movement step is the move period, then CHECK, then one COMMIT cycle per player.
// Backpressure: none; direction requests are sampled every cycle outside CLEAR, and start is a level honoured only in IDLE/OVER.
// Ports: clk/reset (async active-high), start, dir_req {up,down,left,right} per player,
//        px_x/px_y -> pix_owner/pix_head, state, alive, winner, score (8 bits per player).
// Build option: define TRON_SPEEDUP_EN to shorten the move period by MOVE_PERIOD/16 every 64 steps (floor MOVE_PERIOD/4).
module tron_arena_core #(
    parameter int NUM_PLAYERS = 2,
    parameter int GRID_W      = 64,
    parameter int GRID_H      = 48,
    parameter int CELL_SIZE   = 10,
    parameter int MOVE_PERIOD = 4194304,
    parameter int WALL_WRAP   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [4*NUM_PLAYERS-1:0]   dir_req,
    input  logic [9:0]                 px_x,
    input  logic [9:0]                 px_y,
    output logic [2:0]                 pix_owner,
    output logic                       pix_head,
    output logic [2:0]                 state,
    output logic [NUM_PLAYERS-1:0]     alive,
    output logic [2:0]                 winner,
    output logic [8*NUM_PLAYERS-1:0]   score
);
    localparam int CELLS = GRID_W * GRID_H;
    localparam int IW    = $clog2(CELLS);
    localparam int CW    = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int RW    = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int PW    = $clog2(NUM_PLAYERS);
    localparam int MW    = $clog2(MOVE_PERIOD + 1);

    typedef enum logic [1:0] {D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3} dir_t;
    typedef enum logic [2:0] {
        S_CLEAR = 3'd0, S_IDLE = 3'd1, S_SEED = 3'd2, S_PLAY = 3'd3,
        S_CHECK = 3'd4, S_COMMIT = 3'd5, S_OVER = 3'd6
    } state_t;

    function automatic logic [IW-1:0] cell_idx(input logic [CW-1:0] c, input logic [RW-1:0] r);
        return IW'(r) * IW'(GRID_W) + IW'(c);
    endfunction

    // Grid storage is deliberately unreset; CLEAR wipes it.
    logic [2:0]    grid_q [CELLS];

    state_t        state_q;
    logic [IW-1:0] clr_idx_q;
    logic          restart_q;
    logic [PW-1:0] pidx_q;
    logic [MW-1:0] move_cnt_q;
    logic [MW-1:0] period_m1;
    logic [CW-1:0] head_col_q [NUM_PLAYERS];
    logic [RW-1:0] head_row_q [NUM_PLAYERS];
    dir_t          dir_q      [NUM_PLAYERS];
    dir_t          pend_q     [NUM_PLAYERS];
    logic [CW-1:0] nxt_col_q  [NUM_PLAYERS];
    logic [RW-1:0] nxt_row_q  [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] dead_q, alive_q, alive_d;
    logic [2:0]    winner_q, win_d, n_alive;
    logic [7:0]    score_q    [NUM_PLAYERS];
    logic [2:0]    pix_owner_q;
    logic          pix_head_q;

`ifdef TRON_SPEEDUP_EN
    localparam logic [MW-1:0] STEP_DROP  = MW'(MOVE_PERIOD / 16);
    localparam logic [MW-1:0] PERIOD_MIN = MW'(MOVE_PERIOD / 4);
    logic [MW-1:0] period_q;
    logic [5:0]    step_cnt_q;
    assign period_m1 = period_q - 1'b1;
`else
    assign period_m1 = MW'(MOVE_PERIOD - 1);
`endif

    // Combinational next-cell evaluation used by CHECK.
    dir_t          new_dir_c [NUM_PLAYERS];
    logic [CW-1:0] ncol_c    [NUM_PLAYERS];
    logic [RW-1:0] nrow_c    [NUM_PLAYERS];
    logic [IW-1:0] nidx_c    [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] oob_c, dead_c;

    always_comb begin
        oob_c  = '0;
        dead_c = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            // Reversal: same axis (bit 1 equal), opposite sense (bit 0 differs).
            if (pend_q[p][1] == dir_q[p][1] && pend_q[p][0] != dir_q[p][0])
                new_dir_c[p] = dir_q[p];
            else
                new_dir_c[p] = pend_q[p];
            ncol_c[p] = head_col_q[p];
            nrow_c[p] = head_row_q[p];
            case (new_dir_c[p])
                D_UP:    if (head_row_q[p] == '0) begin oob_c[p] = 1'b1; nrow_c[p] = RW'(GRID_H - 1); end
                         else nrow_c[p] = head_row_q[p] - 1'b1;
                D_DOWN:  if (head_row_q[p] == RW'(GRID_H - 1)) begin oob_c[p] = 1'b1; nrow_c[p] = '0; end
                         else nrow_c[p] = head_row_q[p] + 1'b1;
                D_LEFT:  if (head_col_q[p] == '0) begin oob_c[p] = 1'b1; ncol_c[p] = CW'(GRID_W - 1); end
                         else ncol_c[p] = head_col_q[p] - 1'b1;
                default: if (head_col_q[p] == CW'(GRID_W - 1)) begin oob_c[p] = 1'b1; ncol_c[p] = '0; end
                         else ncol_c[p] = head_col_q[p] + 1'b1;
            endcase
            nidx_c[p] = cell_idx(ncol_c[p], nrow_c[p]);
        end
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            dead_c[p] = (oob_c[p] && (WALL_WRAP == 0)) || (grid_q[nidx_c[p]] != 3'd0);
            // Two alive players aiming at the same cell both die.
            for (int q = 0; q < NUM_PLAYERS; q++)
                if (q != p && alive_q[q] && nidx_c[p] == nidx_c[q]) dead_c[p] = 1'b1;
        end
    end

    // Seed position for the player currently addressed by pidx_q.
    logic [CW-1:0] seed_col_c;
    always_comb begin
        seed_col_c = '0;
        for (int p = 0; p < NUM_PLAYERS; p++)
            if (pidx_q == PW'(p)) seed_col_c = CW'((p + 1) * GRID_W / (NUM_PLAYERS + 1));
    end

    // Alive set after the current COMMIT slot, and the resulting winner.
    always_comb begin
        alive_d = alive_q;
        n_alive = '0;
        win_d   = '0;
        for (int p = 0; p < NUM_PLAYERS; p++)
            if (pidx_q == PW'(p) && dead_q[p]) alive_d[p] = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            n_alive = n_alive + {2'b00, alive_d[p]};
            if (alive_d[p]) win_d = 3'(p + 1);
        end
    end

    // Pixel to cell mapping.
    logic [9:0]    pcol, prow;
    logic          pix_in, head_hit;
    logic [IW-1:0] pix_idx;
    always_comb begin
        pcol     = px_x / 10'(CELL_SIZE);
        prow     = px_y / 10'(CELL_SIZE);
        pix_in   = (pcol < 10'(GRID_W)) && (prow < 10'(GRID_H));
        pix_idx  = cell_idx(CW'(pcol), RW'(prow));
        head_hit = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++)
            if (alive_q[p] && head_col_q[p] == CW'(pcol) && head_row_q[p] == RW'(prow)) head_hit = 1'b1;
    end

    // Single grid write port.
    logic          gw_en;
    logic [IW-1:0] gw_idx;
    logic [2:0]    gw_dat;
    always_comb begin
        gw_en  = 1'b0;
        gw_idx = '0;
        gw_dat = '0;
        case (state_q)
            S_CLEAR: begin gw_en = 1'b1; gw_idx = clr_idx_q; end
            S_SEED: begin
                gw_en  = 1'b1;
                gw_idx = cell_idx(seed_col_c, RW'(GRID_H / 2));
                gw_dat = 3'(pidx_q) + 3'd1;
            end
            S_COMMIT:
                for (int p = 0; p < NUM_PLAYERS; p++)
                    if (pidx_q == PW'(p) && alive_q[p] && !dead_q[p]) begin
                        gw_en  = 1'b1;
                        gw_idx = cell_idx(nxt_col_q[p], nxt_row_q[p]);
                        gw_dat = 3'(p + 1);
                    end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (gw_en) grid_q[gw_idx] <= gw_dat;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_CLEAR;
            clr_idx_q   <= '0;
            restart_q   <= 1'b0;
            pidx_q      <= '0;
            move_cnt_q  <= '0;
            alive_q     <= '0;
            dead_q      <= '0;
            winner_q    <= '0;
            pix_owner_q <= '0;
            pix_head_q  <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                head_col_q[p] <= '0;
                head_row_q[p] <= '0;
                nxt_col_q[p]  <= '0;
                nxt_row_q[p]  <= '0;
                dir_q[p]      <= D_RIGHT;
                pend_q[p]     <= D_RIGHT;
                score_q[p]    <= '0;
            end
`ifdef TRON_SPEEDUP_EN
            period_q   <= MW'(MOVE_PERIOD);
            step_cnt_q <= '0;
`endif
        end else begin
            pix_owner_q <= pix_in ? grid_q[pix_idx] : 3'd0;
            pix_head_q  <= pix_in && head_hit &&
                           (state_q == S_PLAY || state_q == S_CHECK || state_q == S_COMMIT);

            // Pending direction: highest-priority held request; SEED loads the start heading otherwise.
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (state_q != S_CLEAR) begin
                    if (dir_req[4*p+3])      pend_q[p] <= D_UP;
                    else if (dir_req[4*p+2]) pend_q[p] <= D_DOWN;
                    else if (dir_req[4*p+1]) pend_q[p] <= D_LEFT;
                    else if (dir_req[4*p])   pend_q[p] <= D_RIGHT;
                    else if (state_q == S_SEED && pidx_q == PW'(p))
                        pend_q[p] <= (p % 2 == 0) ? D_RIGHT : D_LEFT;
                end
            end

            case (state_q)
                S_CLEAR: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == IW'(CELLS - 1)) begin
                        clr_idx_q <= '0;
                        restart_q <= 1'b0;
                        pidx_q    <= '0;
                        state_q   <= restart_q ? S_SEED : S_IDLE;
                    end
                end
                S_IDLE: if (start) begin
                    pidx_q  <= '0;
                    state_q <= S_SEED;
                end
                S_SEED: begin
                    for (int p = 0; p < NUM_PLAYERS; p++)
                        if (pidx_q == PW'(p)) begin
                            head_col_q[p] <= seed_col_c;
                            head_row_q[p] <= RW'(GRID_H / 2);
                            dir_q[p]      <= (p % 2 == 0) ? D_RIGHT : D_LEFT;
                            alive_q[p]    <= 1'b1;
                        end
                    if (pidx_q == PW'(NUM_PLAYERS - 1)) begin
                        pidx_q     <= '0;
                        move_cnt_q <= '0;
                        state_q    <= S_PLAY;
`ifdef TRON_SPEEDUP_EN
                        period_q   <= MW'(MOVE_PERIOD);
                        step_cnt_q <= '0;
`endif
                    end else begin
                        pidx_q <= pidx_q + 1'b1;
                    end
                end
                S_PLAY: begin
                    move_cnt_q <= move_cnt_q + 1'b1;
                    if (move_cnt_q == period_m1) begin
                        move_cnt_q <= '0;
                        state_q    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    for (int p = 0; p < NUM_PLAYERS; p++) begin
                        if (alive_q[p]) dir_q[p] <= new_dir_c[p];
                        nxt_col_q[p] <= ncol_c[p];
                        nxt_row_q[p] <= nrow_c[p];
                    end
                    dead_q  <= dead_c & alive_q;
                    pidx_q  <= '0;
                    state_q <= S_COMMIT;
`ifdef TRON_SPEEDUP_EN
                    step_cnt_q <= step_cnt_q + 1'b1;
                    if (step_cnt_q == 6'd63) begin
                        if (period_q >= PERIOD_MIN + STEP_DROP) period_q <= period_q - STEP_DROP;
                        else                                    period_q <= PERIOD_MIN;
                    end
`endif
                end
                S_COMMIT: begin
                    alive_q <= alive_d;
                    for (int p = 0; p < NUM_PLAYERS; p++)
                        if (pidx_q == PW'(p) && alive_q[p] && !dead_q[p]) begin
                            head_col_q[p] <= nxt_col_q[p];
                            head_row_q[p] <= nxt_row_q[p];
                        end
                    if (pidx_q == PW'(NUM_PLAYERS - 1)) begin
                        pidx_q <= '0;
                        if (n_alive <= 3'd1) begin
                            state_q  <= S_OVER;
                            winner_q <= win_d;
                            for (int p = 0; p < NUM_PLAYERS; p++)
                                if (alive_d[p] && score_q[p] != 8'hFF) score_q[p] <= score_q[p] + 1'b1;
                        end else begin
                            state_q <= S_PLAY;
                        end
                    end else begin
                        pidx_q <= pidx_q + 1'b1;
                    end
                end
                S_OVER: if (start) begin
                    winner_q  <= '0;
                    alive_q   <= '0;
                    restart_q <= 1'b1;
                    state_q   <= S_CLEAR;
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

    assign pix_owner = pix_owner_q;
    assign pix_head  = pix_head_q;
    assign state     = state_q;
    assign alive     = alive_q;
    assign winner    = winner_q;
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_score
        assign score[8*p +: 8] = score_q[p];
    end
endmodule

// File: tb/tb_tron_arena_core.sv
// Bench for tron_arena_core: two instances (lethal walls "L", wrapping walls "W") share stimulus.
// Pixel reads go through a scoreboard queue; all other observations use the same check task.
module tb_tron_arena_core;
    localparam int NP = 2, GW = 8, GH = 4, CS = 10, MP = 4;
    localparam logic [2:0] S_CLEAR = 3'd0, S_IDLE = 3'd1, S_PLAY = 3'd3,
                           S_CHECK = 3'd4, S_COMMIT = 3'd5, S_OVER = 3'd6;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [7:0]  dir_req;
    logic [9:0]  px_x, px_y;
    logic [2:0]  own_l, own_w, st_l, st_w, win_l, win_w;
    logic        head_l, head_w;
    logic [1:0]  alive_l, alive_w;
    logic [15:0] score_l, score_w;

    tron_arena_core #(.NUM_PLAYERS(NP), .GRID_W(GW), .GRID_H(GH), .CELL_SIZE(CS),
                      .MOVE_PERIOD(MP), .WALL_WRAP(0)) dut_l (
        .clk(clk), .reset(reset), .start(start), .dir_req(dir_req), .px_x(px_x), .px_y(px_y),
        .pix_owner(own_l), .pix_head(head_l), .state(st_l), .alive(alive_l),
        .winner(win_l), .score(score_l));

    tron_arena_core #(.NUM_PLAYERS(NP), .GRID_W(GW), .GRID_H(GH), .CELL_SIZE(CS),
                      .MOVE_PERIOD(MP), .WALL_WRAP(1)) dut_w (
        .clk(clk), .reset(reset), .start(start), .dir_req(dir_req), .px_x(px_x), .px_y(px_y),
        .pix_owner(own_w), .pix_head(head_w), .state(st_w), .alive(alive_w),
        .winner(win_w), .score(score_w));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         sel;
        int         col;
        int         row;
        logic [2:0] owner;
        logic       head;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a pixel at the centre of a cell, queue the expectation, compare one cycle later.
    task automatic probe(input int sel, input int col, input int row,
                         input logic [2:0] eo, input logic eh);
        exp_t e;
        px_x = 10'(col * CS + 5);
        px_y = 10'(row * CS + 5);
        e.sel = sel; e.col = col; e.row = row; e.owner = eo; e.head = eh;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        check($sformatf("owner_%s(%0d,%0d)", e.sel ? "W" : "L", e.col, e.row),
              e.sel ? 32'(own_w) : 32'(own_l), 32'(e.owner));
        check($sformatf("head_%s(%0d,%0d)", e.sel ? "W" : "L", e.col, e.row),
              e.sel ? 32'(head_w) : 32'(head_l), 32'(e.head));
    endtask

    task automatic wait_any(input logic [2:0] s1, input logic [2:0] s2, input int budget);
        int n = 0;
        while (st_l !== s1 && st_l !== s2 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (st_l !== s1 && st_l !== s2) check("wait_state_timeout", st_l, s1);
    endtask

    task automatic wait_step();
        wait_any(S_CHECK, S_CHECK, 20);
        wait_any(S_PLAY, S_OVER, 20);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, "_state"}, st_l, S_CLEAR);
        check({tag, "_alive"}, alive_l, 0);
        check({tag, "_winner"}, win_l, 0);
        check({tag, "_score"}, score_l, 0);
        check({tag, "_pix_owner"}, own_l, 0);
        check({tag, "_pix_head"}, head_l, 0);
        check({tag, "_state_w"}, st_w, S_CLEAR);
    endtask

    // Release reset (called at a negedge) and count cycles spent in CLEAR.
    task automatic release_reset();
        int n = 0;
        reset = 1'b0;
        while (st_l === S_CLEAR && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("clear_cycles", n, GW * GH);
        check("idle_L", st_l, S_IDLE);
        check("idle_W", st_w, S_IDLE);
    endtask

    task automatic full_reset();
        reset = 1'b1;
        start = 1'b0;
        dir_req = '0;
        @(negedge clk);
        @(negedge clk);
        release_reset();
    endtask

    task automatic sweep_zero();
        for (int s = 0; s < 2; s++)
            for (int r = 0; r < GH; r++)
                for (int c = 0; c < GW; c++)
                    probe(s, c, r, 3'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; dir_req = '0; px_x = '0; px_y = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset: outputs, 32 CLEAR cycles, empty grid, out-of-grid pixel.
        reset_outputs("por");
        release_reset();
        sweep_zero();
        probe(0, 9, 1, 3'd0, 1'b0);

        // Start, seed and first step.
        pulse_start();
        wait_any(S_PLAY, S_PLAY, 20);
        probe(0, 2, 2, 3'd1, 1'b1);
        probe(0, 5, 2, 3'd2, 1'b1);
        probe(1, 2, 2, 3'd1, 1'b1);
        probe(1, 5, 2, 3'd2, 1'b1);
        wait_step();
        check("step1_alive", alive_l, 2'b11);
        probe(0, 3, 2, 3'd1, 1'b1);
        probe(0, 4, 2, 3'd2, 1'b1);
        probe(0, 2, 2, 3'd1, 1'b0);
        probe(1, 3, 2, 3'd1, 1'b1);

        // Second step: head-on, both die.
        wait_step();
        check("headon_state_L", st_l, S_OVER);
        check("headon_state_W", st_w, S_OVER);
        check("headon_alive", alive_l, 0);
        check("headon_winner", win_l, 0);
        check("headon_score", score_l, 0);
        check("headon_winner_W", win_w, 0);
        probe(0, 3, 2, 3'd1, 1'b0);

        // Wall: player 0 turns up; player 1 turns down before reaching player 0's trail.
        full_reset();
        dir_req = 8'b0000_1000;
        pulse_start();
        wait_any(S_PLAY, S_PLAY, 20);
        dir_req = '0;
        wait_step();
        probe(0, 2, 1, 3'd1, 1'b1);
        probe(1, 2, 1, 3'd1, 1'b1);
        wait_step();
        probe(0, 2, 0, 3'd1, 1'b1);
        probe(0, 3, 2, 3'd2, 1'b1);
        dir_req = 8'b0100_0000;
        wait_step();
        dir_req = '0;
        check("wall_state_L", st_l, S_OVER);
        check("wall_winner_L", win_l, 3'd2);
        check("wall_score_L", score_l, 16'h0100);
        check("wall_alive_L", alive_l, 2'b10);
        check("wrap_state_W", st_w, S_PLAY);
        check("wrap_alive_W", alive_w, 2'b11);
        probe(1, 2, 3, 3'd1, 1'b1);
        probe(1, 3, 3, 3'd2, 1'b1);
        probe(0, 2, 0, 3'd1, 1'b0);

        // Reversal ignored, then up beats right.
        full_reset();
        dir_req = 8'b0000_0010;
        pulse_start();
        wait_any(S_PLAY, S_PLAY, 20);
        wait_step();
        probe(0, 3, 2, 3'd1, 1'b1);
        dir_req = 8'b0000_1001;
        wait_step();
        dir_req = '0;
        check("prio_state", st_l, S_OVER);
        check("prio_winner", win_l, 3'd1);
        check("prio_score", score_l, 16'h0001);
        check("prio_alive", alive_l, 2'b01);
        check("prio_winner_W", win_w, 3'd1);
        probe(0, 3, 1, 3'd1, 1'b0);
        probe(1, 3, 1, 3'd1, 1'b0);
        probe(0, 3, 2, 3'd1, 1'b0);

        // Restart from OVER: CLEAR then straight to SEED; score retained.
        pulse_start();
        check("restart_clear", st_l, S_CLEAR);
        check("restart_winner", win_l, 0);
        wait_any(S_PLAY, S_PLAY, 100);
        check("restart_score", score_l, 16'h0001);
        probe(0, 3, 1, 3'd0, 1'b0);
        probe(0, 2, 2, 3'd1, 1'b1);

        // Reset during COMMIT.
        wait_any(S_COMMIT, S_COMMIT, 20);
        check("pre_reset_owner", own_l, 3'd1);
        reset = 1'b1;
        #1;
        reset_outputs("mid");
        @(negedge clk);
        @(negedge clk);
        release_reset();
        check("post_reset_score", score_l, 0);
        sweep_zero();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end
endmodule
